// File: rtl/debug_snapshot_ctrl.sv
// Snapshot sequencer: copies a 32-word page of a CPU-side array into the debug
// display's shadow buffer, sharing the array's read port with the CPU.
module debug_snapshot_ctrl #(
  parameter int NUM_WORDS = 32,
  parameter int IDX_W     = 5,
  parameter int PAGE_W    = 2,
  parameter int DATA_W    = 32,
  parameter int FRAME_DIV = 15
) (
  input  logic                    clk,
  input  logic                    rstb,
  input  logic                    vsync,
  input  logic                    freeze,
  input  logic                    capture_now,
  input  logic [PAGE_W-1:0]       page_sel,
  input  logic                    cpu_req,
  input  logic [PAGE_W+IDX_W-1:0] cpu_addr,
  output logic                    cpu_grant,
  output logic [PAGE_W+IDX_W-1:0] port_addr,
  input  logic [DATA_W-1:0]       port_rdata,
  output logic                    snap_we,
  output logic [IDX_W-1:0]        snap_waddr,
  output logic [DATA_W-1:0]       snap_wdata,
  output logic                    busy,
  output logic                    snap_done,
  output logic [PAGE_W-1:0]       snap_page
);

  localparam int CNT_W = (FRAME_DIV > 0) ? $clog2(FRAME_DIV + 1) : 1;
  localparam logic [CNT_W-1:0] DIV_MAX  = CNT_W'(FRAME_DIV);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t             state, state_next;
  logic               vsync_d;
  logic [CNT_W-1:0]   frame_cnt;
  logic               pending;
  logic [PAGE_W-1:0]  page_q;
  logic [IDX_W-1:0]   idx;
  logic               issued;
  logic [IDX_W-1:0]   iss_idx;

  logic fe;
  logic auto_trig;
  logic trig;
  logic scan_issue;

  assign fe         = vsync & ~vsync_d;
  assign auto_trig  = fe & (frame_cnt == DIV_MAX);
  assign trig       = (auto_trig & ~freeze) | capture_now | pending;
  assign scan_issue = (state == SCAN) & ~cpu_req;

  // The CPU always wins the read port; the scanner only uses idle cycles.
  assign cpu_grant = cpu_req;
  assign port_addr = cpu_req ? cpu_addr : {page_q, idx};

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (trig) state_next = SCAN;
      SCAN:    if (scan_issue && (idx == LAST_IDX)) state_next = DRAIN;
      DRAIN:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state      <= IDLE;
      vsync_d    <= 1'b0;
      frame_cnt  <= '0;
      pending    <= 1'b0;
      page_q     <= '0;
      idx        <= '0;
      issued     <= 1'b0;
      iss_idx    <= '0;
      snap_we    <= 1'b0;
      snap_waddr <= '0;
      snap_wdata <= '0;
      busy       <= 1'b0;
      snap_done  <= 1'b0;
      snap_page  <= '0;
    end else begin
      state   <= state_next;
      vsync_d <= vsync;

      // Frame divider keeps running through freeze and busy periods.
      if (fe) begin
        if (frame_cnt == DIV_MAX) frame_cnt <= '0;
        else                      frame_cnt <= frame_cnt + CNT_W'(1);
      end

      // Only on-demand requests survive a busy window; automatic ones are dropped.
      if (state == IDLE && trig)          pending <= 1'b0;
      else if (state != IDLE && capture_now) pending <= 1'b1;

      if (state == IDLE && trig) begin
        page_q <= page_sel;
        idx    <= '0;
        busy   <= 1'b1;
      end

      issued <= scan_issue;
      if (scan_issue) begin
        iss_idx <= idx;
        idx     <= idx + IDX_W'(1);
      end

      // Read data returns one cycle after its address, tagged by iss_idx.
      snap_we <= issued;
      if (issued) begin
        snap_waddr <= iss_idx;
        snap_wdata <= port_rdata;
      end

      snap_done <= (state == DONE);
      if (state == DONE) begin
        snap_page <= page_q;
        busy      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_debug_snapshot_ctrl.sv
// Directed bench for debug_snapshot_ctrl: a registered-read memory model feeds
// the port and a monitor collects shadow-buffer writes and capture timing.
module tb_debug_snapshot_ctrl;

  logic        clk = 1'b0;
  logic        rstb;
  logic        vsync;
  logic        freeze;
  logic        capture_now;
  logic [1:0]  page_sel;
  logic        cpu_req;
  logic [6:0]  cpu_addr;
  logic        cpu_grant;
  logic [6:0]  port_addr;
  logic [31:0] port_rdata;
  logic        snap_we;
  logic [4:0]  snap_waddr;
  logic [31:0] snap_wdata;
  logic        busy;
  logic        snap_done;
  logic [1:0]  snap_page;

  int checks = 0;
  int fails  = 0;
  int fe_total = 0;

  int cyc = 0;
  int starts = 0;
  int dones = 0;
  int writes = 0;
  int order_err = 0;
  int exp_next = 0;
  int last_start = 0;
  int last_done = 0;
  logic busy_prev = 1'b0;
  logic [31:0] shadow [32];

  debug_snapshot_ctrl dut (
    .clk(clk), .rstb(rstb), .vsync(vsync), .freeze(freeze),
    .capture_now(capture_now), .page_sel(page_sel), .cpu_req(cpu_req),
    .cpu_addr(cpu_addr), .cpu_grant(cpu_grant), .port_addr(port_addr),
    .port_rdata(port_rdata), .snap_we(snap_we), .snap_waddr(snap_waddr),
    .snap_wdata(snap_wdata), .busy(busy), .snap_done(snap_done),
    .snap_page(snap_page)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [31:0] model_word(input logic [6:0] a);
    return {1'b0, a, 8'h5A, ~{1'b0, a}, 8'hC3};
  endfunction

  function automatic int count_bad(input logic [1:0] pg);
    int n = 0;
    for (int i = 0; i < 32; i++)
      if (shadow[i] !== model_word({pg, i[4:0]})) n++;
    return n;
  endfunction

  // Source array with one cycle of read latency.
  always @(posedge clk) port_rdata <= model_word(port_addr);

  always @(posedge clk) cyc <= cyc + 1;

  // Collects captures: start/done cycles and the ordered stream of writes.
  always @(negedge clk) begin
    if (busy && !busy_prev) begin
      starts     = starts + 1;
      last_start = cyc;
      exp_next   = 0;
    end
    if (snap_done) begin
      dones     = dones + 1;
      last_done = cyc;
    end
    if (snap_we) begin
      shadow[snap_waddr] = snap_wdata;
      if (int'(snap_waddr) != exp_next) order_err = order_err + 1;
      exp_next = exp_next + 1;
      writes   = writes + 1;
    end
    busy_prev = busy;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    tick();
    tick();
    tick();
    fe_total++;
  endtask

  task automatic wait_done(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (dones >= target) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic test_reset();
    rstb = 1'b0; vsync = 1'b0; freeze = 1'b0; capture_now = 1'b0;
    page_sel = 2'd0; cpu_req = 1'b0; cpu_addr = 7'd0;
    tick();
    tick();
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    checks++; if (snap_we !== 1'b0) begin fails++; $display("[TB] FAIL reset_we: got %b want 0", snap_we); end
    checks++; if (snap_done !== 1'b0) begin fails++; $display("[TB] FAIL reset_done: got %b want 0", snap_done); end
    checks++; if (snap_page !== 2'd0) begin fails++; $display("[TB] FAIL reset_page: got %0d want 0", snap_page); end
    checks++; if (snap_waddr !== 5'd0 || snap_wdata !== 32'd0) begin fails++; $display("[TB] FAIL reset_wbus: got %0d/%h want 0/0", snap_waddr, snap_wdata); end
    checks++; if (port_addr !== 7'd0) begin fails++; $display("[TB] FAIL reset_port_addr: got %0d want 0", port_addr); end
    rstb = 1'b1;
    tick();
    cpu_req = 1'b1; cpu_addr = 7'h2B;
    #1;
    checks++; if (cpu_grant !== 1'b1) begin fails++; $display("[TB] FAIL idle_grant: got %b want 1", cpu_grant); end
    checks++; if (port_addr !== 7'h2B) begin fails++; $display("[TB] FAIL idle_cpu_addr: got %h want 2b", port_addr); end
    cpu_req = 1'b0;
    tick();
  endtask

  task automatic test_auto_cadence();
    int s0, d0, w0;
    bit ok;
    freeze = 1'b0; page_sel = 2'd0;
    s0 = starts; d0 = dones; w0 = writes;
    for (int f = 1; f <= 40; f++) begin
      if (f == 28) begin
        checks++; if (last_done - last_start !== 34) begin fails++; $display("[TB] FAIL auto_latency1: got %0d want 35", last_done - last_start + 1); end
        checks++; if (count_bad(2'd0) !== 0) begin fails++; $display("[TB] FAIL auto_data1: %0d bad words, want 0", count_bad(2'd0)); end
        checks++; if (snap_page !== 2'd0) begin fails++; $display("[TB] FAIL auto_page1: got %0d want 0", snap_page); end
        page_sel = 2'd1;
      end
      frame();
      checks++;
      if (starts !== s0 + ((f >= 32) ? 2 : (f >= 16) ? 1 : 0)) begin
        fails++; $display("[TB] FAIL auto_starts_f%0d: got %0d want %0d", f, starts - s0, (f >= 32) ? 2 : (f >= 16) ? 1 : 0);
      end
    end
    wait_done(d0 + 2, ok);
    checks++; if (!ok) begin fails++; $display("[TB] FAIL auto_timeout: dones %0d want %0d", dones - d0, 2); end
    checks++; if (last_done - last_start !== 34) begin fails++; $display("[TB] FAIL auto_latency2: got %0d want 35", last_done - last_start + 1); end
    checks++; if (count_bad(2'd1) !== 0) begin fails++; $display("[TB] FAIL auto_data2: %0d bad words, want 0", count_bad(2'd1)); end
    checks++; if (snap_page !== 2'd1) begin fails++; $display("[TB] FAIL auto_page2: got %0d want 1", snap_page); end
    checks++; if (writes - w0 !== 64) begin fails++; $display("[TB] FAIL auto_writes: got %0d want 64", writes - w0); end
    checks++; if (order_err !== 0) begin fails++; $display("[TB] FAIL auto_order: got %0d errors want 0", order_err); end
  endtask

  task automatic test_cpu_contention();
    int d0, w0, exp_idx, k;
    logic req;
    logic [6:0] exp_addr;
    bit ok;
    page_sel = 2'd0; d0 = dones; w0 = writes;
    capture_now = 1'b1;
    tick();
    capture_now = 1'b0;
    exp_idx = 0; k = 0;
    while (exp_idx < 32 && k < 60) begin
      req = (k == 3) || (k == 4) || (k == 10);
      cpu_req = req;
      cpu_addr = {2'b11, k[4:0]};
      #1;
      exp_addr = req ? {2'b11, k[4:0]} : {2'b00, exp_idx[4:0]};
      checks++; if (cpu_grant !== req) begin fails++; $display("[TB] FAIL cont_grant_k%0d: got %b want %b", k, cpu_grant, req); end
      checks++; if (port_addr !== exp_addr) begin fails++; $display("[TB] FAIL cont_addr_k%0d: got %0d want %0d", k, port_addr, exp_addr); end
      if (!req) exp_idx++;
      tick();
      k++;
    end
    cpu_req = 1'b0;
    wait_done(d0 + 1, ok);
    checks++; if (!ok) begin fails++; $display("[TB] FAIL cont_timeout: no snap_done"); end
    checks++; if (last_done - last_start !== 37) begin fails++; $display("[TB] FAIL cont_latency: got %0d want 38", last_done - last_start + 1); end
    checks++; if (count_bad(2'd0) !== 0) begin fails++; $display("[TB] FAIL cont_data: %0d bad words, want 0", count_bad(2'd0)); end
    checks++; if (writes - w0 !== 32) begin fails++; $display("[TB] FAIL cont_writes: got %0d want 32", writes - w0); end
    checks++; if (order_err !== 0) begin fails++; $display("[TB] FAIL cont_order: got %0d errors want 0", order_err); end
  endtask

  task automatic test_freeze_capture();
    int s0, d0;
    bit ok;
    freeze = 1'b1; s0 = starts; d0 = dones;
    for (int f = 0; f < 48; f++) frame();
    checks++; if (starts !== s0) begin fails++; $display("[TB] FAIL freeze_starts: got %0d want 0", starts - s0); end
    page_sel = 2'd2;
    capture_now = 1'b1;
    tick();
    capture_now = 1'b0; page_sel = 2'd0;
    checks++; if (port_addr !== 7'd64) begin fails++; $display("[TB] FAIL freeze_first_addr: got %0d want 64", port_addr); end
    wait_done(d0 + 1, ok);
    checks++; if (!ok) begin fails++; $display("[TB] FAIL freeze_timeout: no snap_done"); end
    checks++; if (starts !== s0 + 1) begin fails++; $display("[TB] FAIL freeze_single: got %0d starts want 1", starts - s0); end
    checks++; if (snap_page !== 2'd2) begin fails++; $display("[TB] FAIL freeze_page: got %0d want 2", snap_page); end
    checks++; if (count_bad(2'd2) !== 0) begin fails++; $display("[TB] FAIL freeze_data: %0d bad words, want 0", count_bad(2'd2)); end
  endtask

  task automatic test_page_change();
    int d0, bad_addr;
    bit ok;
    freeze = 1'b0; page_sel = 2'd0; d0 = dones; bad_addr = 0;
    capture_now = 1'b1;
    tick();
    capture_now = 1'b0;
    for (int k = 0; k < 32; k++) begin
      if (k == 12) page_sel = 2'd3;
      if (port_addr !== {2'b00, k[4:0]}) bad_addr++;
      tick();
    end
    checks++; if (bad_addr !== 0) begin fails++; $display("[TB] FAIL page_addr: %0d off-page reads, want 0", bad_addr); end
    wait_done(d0 + 1, ok);
    checks++; if (!ok) begin fails++; $display("[TB] FAIL page_timeout: no snap_done"); end
    checks++; if (snap_page !== 2'd0) begin fails++; $display("[TB] FAIL page_snap_page: got %0d want 0", snap_page); end
    checks++; if (count_bad(2'd0) !== 0) begin fails++; $display("[TB] FAIL page_data: %0d bad words, want 0", count_bad(2'd0)); end
    page_sel = 2'd0;
  endtask

  task automatic test_back_to_back();
    int s0, d0, n, done1;
    bit ok;
    freeze = 1'b0; page_sel = 2'd0; s0 = starts; d0 = dones;
    n = 16 - (fe_total % 16);
    capture_now = 1'b1;
    tick();
    capture_now = 1'b0;
    for (int k = 0; k < 34; k++) begin
      vsync = (k < 2 * n) && (k % 2 == 0);
      if (vsync) fe_total++;
      capture_now = (k == 5);
      if (k == 5) page_sel = 2'd1;
      tick();
    end
    vsync = 1'b0; capture_now = 1'b0;
    wait_done(d0 + 1, ok);
    checks++; if (!ok) begin fails++; $display("[TB] FAIL b2b_timeout1: no snap_done"); end
    done1 = last_done;
    checks++; if (snap_page !== 2'd0) begin fails++; $display("[TB] FAIL b2b_page1: got %0d want 0", snap_page); end
    wait_done(d0 + 2, ok);
    checks++; if (!ok) begin fails++; $display("[TB] FAIL b2b_timeout2: no second snap_done"); end
    checks++; if (last_start !== done1 + 1) begin fails++; $display("[TB] FAIL b2b_restart: start at +%0d want +1 after done", last_start - done1); end
    checks++; if (snap_page !== 2'd1) begin fails++; $display("[TB] FAIL b2b_page2: got %0d want 1", snap_page); end
    checks++; if (count_bad(2'd1) !== 0) begin fails++; $display("[TB] FAIL b2b_data: %0d bad words, want 0", count_bad(2'd1)); end
    for (int i = 0; i < 60; i++) tick();
    checks++; if (starts !== s0 + 2) begin fails++; $display("[TB] FAIL b2b_starts: got %0d want 2", starts - s0); end
    checks++; if (order_err !== 0) begin fails++; $display("[TB] FAIL b2b_order: got %0d errors want 0", order_err); end
  endtask

  task automatic test_reset_mid_scan();
    int s0, d0;
    bit ok;
    freeze = 1'b1;
    for (int f = 0; f < 5; f++) frame();
    freeze = 1'b0; page_sel = 2'd1;
    capture_now = 1'b1;
    tick();
    capture_now = 1'b0;
    for (int k = 0; k < 20; k++) tick();
    checks++; if (port_addr !== {2'b01, 5'd20}) begin fails++; $display("[TB] FAIL rst_pre_addr: got %0d want %0d", port_addr, {2'b01, 5'd20}); end
    rstb = 1'b0;
    tick();
    rstb = 1'b1;
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL rst_busy: got %b want 0", busy); end
    checks++; if (snap_we !== 1'b0) begin fails++; $display("[TB] FAIL rst_we: got %b want 0", snap_we); end
    checks++; if (snap_page !== 2'd0) begin fails++; $display("[TB] FAIL rst_page: got %0d want 0", snap_page); end
    fe_total = 0;
    s0 = starts; d0 = dones; page_sel = 2'd2;
    for (int f = 0; f < 15; f++) frame();
    checks++; if (starts !== s0) begin fails++; $display("[TB] FAIL rst_counter: got %0d starts before fe16 want 0", starts - s0); end
    vsync = 1'b1; capture_now = 1'b1;
    tick();
    vsync = 1'b0; capture_now = 1'b0; fe_total++;
    checks++; if (busy !== 1'b1 || port_addr !== {2'b10, 5'd0}) begin fails++; $display("[TB] FAIL rst_restart: busy=%b addr=%0d want 1/%0d", busy, port_addr, {2'b10, 5'd0}); end
    wait_done(d0 + 1, ok);
    checks++; if (!ok) begin fails++; $display("[TB] FAIL rst_timeout: no snap_done"); end
    for (int i = 0; i < 50; i++) tick();
    checks++; if (starts !== s0 + 1) begin fails++; $display("[TB] FAIL rst_single: got %0d starts want 1", starts - s0); end
    checks++; if (count_bad(2'd2) !== 0) begin fails++; $display("[TB] FAIL rst_data: %0d bad words, want 0", count_bad(2'd2)); end
    checks++; if (order_err !== 0) begin fails++; $display("[TB] FAIL rst_order: got %0d errors want 0", order_err); end
  endtask

  initial begin
    test_reset();
    test_auto_cadence();
    test_cpu_contention();
    test_freeze_capture();
    test_page_change();
    test_back_to_back();
    test_reset_mid_scan();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
